// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: PC width, reset vector, PC increment
// and the PC value type. Imported by the program counter and its helpers.
package mips_pkg;

    localparam int unsigned          PC_WIDTH        = 32;
    localparam logic [PC_WIDTH-1:0]  PC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned          PC_INCR         = 4;

    typedef logic [PC_WIDTH-1:0] pc_t;

endpackage : mips_pkg

// File: rtl/program_counter_if.sv
// Program counter bus: next-PC input with its load enable, plus the current
// PC and PC+4 outputs. With PC_ALIGN_CHECK_EN defined the bus also carries
// the registered PC_misaligned flag.
//
// Handshake: there is no valid/ready pair. PC_write acts as a per-cycle load
// enable sampled on the rising clock edge together with PC_in; the PC side
// is always ready, and PC_out/PC_plus4 are valid every cycle out of reset.
interface program_counter_if
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH
);

    logic             PC_write;
    logic [WIDTH-1:0] PC_in;
    logic [WIDTH-1:0] PC_out;
    logic [WIDTH-1:0] PC_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic             PC_misaligned;
`endif

    // Next-PC mux side: drives the load, observes the current PC.
    modport master (
        output PC_write,
        output PC_in,
        input  PC_out,
        input  PC_plus4
`ifdef PC_ALIGN_CHECK_EN
        ,
        input  PC_misaligned
`endif
    );

    // Program counter side: accepts the load, presents the current PC.
    modport slave (
        input  PC_write,
        input  PC_in,
        output PC_out,
        output PC_plus4
`ifdef PC_ALIGN_CHECK_EN
        ,
        output PC_misaligned
`endif
    );

endinterface : program_counter_if

// File: rtl/pc_incrementer.sv
// Combinational PC incrementer: pc_out = pc_in + INCR, modulo 2^WIDTH.
// The carry out of the top bit is dropped so the PC wraps silently.
module pc_incrementer
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH,
    parameter int unsigned INCR  = PC_INCR
) (
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_out
);

    localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

    // Add the fixed increment; width-limited sum gives the wrap for free.
    always_comb begin
        pc_out = pc_in + INCR_W;
    end

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Program counter register for the single-cycle MIPS datapath.
// Loads PC_in on each rising clk edge when PC_write is high, holds otherwise,
// and resets asynchronously (active-low) to RESET_VECTOR. PC_plus4 is derived
// from the registered PC only, so there is no path from PC_in to either output.
// Optional feature macro: PC_ALIGN_CHECK_EN -- forces word alignment of the
// stored PC and adds the registered PC_misaligned flag.
module program_counter
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              rst_n,
    program_counter_if.slave  bus
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus4;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_d;
    logic misaligned_q;

    // Next state: on a load store the word-aligned PC and flag low bits;
    // on a stall keep both, so PC_in contents are never looked at.
    always_comb begin
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        if (bus.PC_write) begin
            pc_d         = {bus.PC_in[WIDTH-1:2], 2'b00};
            misaligned_d = |bus.PC_in[1:0];
        end
    end

    // PC and misalignment flag registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.PC_misaligned = misaligned_q;
`else
    // Next state: take PC_in verbatim on a load; hold on a stall without
    // looking at PC_in, so an unknown PC_in cannot leak into the PC.
    always_comb begin
        pc_d = pc_q;
        if (bus.PC_write) begin
            pc_d = bus.PC_in;
        end
    end

    // PC register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

    pc_incrementer #(
        .WIDTH (WIDTH),
        .INCR  (PC_INCR)
    ) u_pc_incrementer (
        .pc_in  (pc_q),
        .pc_out (pc_plus4)
    );

    assign bus.PC_out   = pc_q;
    assign bus.PC_plus4 = pc_plus4;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: reset, load, mid-cycle input change,
// stall (including an unknown PC_in), wrap of PC+4, and asynchronous reset
// both between edges and held across an edge. Clock period 10, rising edges
// at t = 5, 15, 25, ...
module tb_program_counter;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_fail;

    program_counter_if #(.WIDTH(32)) pc_bus ();

    program_counter #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pc_bus.slave)
    );

    // Clock: low at t = 0, rising edges at 5 + 10k.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to an absolute simulation time.
    task automatic at(input int t);
        #(t - $time);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mis(input string tag, input logic exp);
`ifdef PC_ALIGN_CHECK_EN
        n_vec++;
        assert (pc_bus.PC_misaligned === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, pc_bus.PC_misaligned, exp);
        end
`else
        if (exp === 1'bx) $display("unreachable %s", tag);
`endif
    endtask

    // Expected stored values; with alignment forced the low two bits clear.
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_A2CA   = 32'hA2CA_5E28;
    localparam logic [31:0] EXP_A2CA_4 = 32'hA2CA_5E2C;
    localparam logic [31:0] EXP_AACE   = 32'hAACE_5E2C;
    localparam logic [31:0] EXP_AACE_4 = 32'hAACE_5E30;
    localparam logic [31:0] EXP_3      = 32'h0000_0000;
    localparam logic [31:0] EXP_3_4    = 32'h0000_0004;
`else
    localparam logic [31:0] EXP_A2CA   = 32'hA2CA_5E2B;
    localparam logic [31:0] EXP_A2CA_4 = 32'hA2CA_5E2F;
    localparam logic [31:0] EXP_AACE   = 32'hAACE_5E2F;
    localparam logic [31:0] EXP_AACE_4 = 32'hAACE_5E33;
    localparam logic [31:0] EXP_3      = 32'h0000_0003;
    localparam logic [31:0] EXP_3_4    = 32'h0000_0007;
`endif

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // Reset asserted between edges: outputs go to reset values at once.
        rst_n           = 1'b1;
        pc_bus.PC_write = 1'b1;
        pc_bus.PC_in    = 32'hA2CA_5E2B;
        at(1);
        rst_n = 1'b0;
        at(2);
        check("reset_pc", pc_bus.PC_out, 32'h0000_0000);
        check("reset_plus4", pc_bus.PC_plus4, 32'h0000_0004);
        check_mis("reset_mis", 1'b0);
        at(3);
        rst_n = 1'b1;
        at(4);
        check("reset_hold_pc", pc_bus.PC_out, 32'h0000_0000);

        // First load on the edge at t = 5.
        at(6);
        check("load_pc", pc_bus.PC_out, EXP_A2CA);
        check("load_plus4", pc_bus.PC_plus4, EXP_A2CA_4);
        check_mis("load_mis", 1'b1);

        // Mid-cycle change at t = 32 is invisible until the edge at t = 35.
        at(32);
        pc_bus.PC_in = 32'hAACE_5E2F;
        at(33);
        check("midcyc_before", pc_bus.PC_out, EXP_A2CA);
        at(36);
        check("midcyc_after", pc_bus.PC_out, EXP_AACE);
        check("midcyc_plus4", pc_bus.PC_plus4, EXP_AACE_4);
        at(82);
        check("midcyc_stable", pc_bus.PC_out, EXP_AACE);

        // Stall for three edges (85, 95, 105) with a new PC_in pending.
        at(83);
        pc_bus.PC_write = 1'b0;
        pc_bus.PC_in    = 32'h0040_0010;
        at(106);
        check("stall_pc", pc_bus.PC_out, EXP_AACE);
        check_mis("stall_mis", 1'b1);

        // Unknown PC_in while stalled must not disturb the PC (edge 115).
        at(107);
        pc_bus.PC_in = 'x;
        at(116);
        check("stall_x_pc", pc_bus.PC_out, EXP_AACE);
        check("stall_x_plus4", pc_bus.PC_plus4, EXP_AACE_4);

        // Resume loading: edge at 125 takes 0x0040_0010.
        at(117);
        pc_bus.PC_in    = 32'h0040_0010;
        pc_bus.PC_write = 1'b1;
        at(126);
        check("resume_pc", pc_bus.PC_out, 32'h0040_0010);
        check("resume_plus4", pc_bus.PC_plus4, 32'h0040_0014);
        check_mis("resume_mis", 1'b0);

        // Asynchronous reset pulse between edges discards the current PC.
        at(128);
        rst_n = 1'b0;
        at(129);
        check("async_rst_pc", pc_bus.PC_out, 32'h0000_0000);
        check("async_rst_plus4", pc_bus.PC_plus4, 32'h0000_0004);
        at(130);
        rst_n = 1'b1;
        at(131);
        pc_bus.PC_in = 32'h0040_0020;
        check("async_rel_pc", pc_bus.PC_out, 32'h0000_0000);
        at(136);
        check("async_reload_pc", pc_bus.PC_out, 32'h0040_0020);

        // PC+4 wraps silently at the top of the address space (edge 145).
        at(137);
        pc_bus.PC_in = 32'hFFFF_FFFC;
        at(146);
        check("wrap_pc", pc_bus.PC_out, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_bus.PC_plus4, 32'h0000_0000);

        // Reset held low across the edge at 155 keeps the reset vector.
        at(147);
        rst_n        = 1'b0;
        pc_bus.PC_in = 32'h1234_5678;
        at(156);
        check("rst_held_pc", pc_bus.PC_out, 32'h0000_0000);
        at(157);
        rst_n = 1'b1;
        at(166);
        check("rst_held_reload", pc_bus.PC_out, 32'h1234_5678);
        check("rst_held_plus4", pc_bus.PC_plus4, 32'h1234_567C);

        // Low bits set: passed through, or aligned and flagged (edge 175).
        at(167);
        pc_bus.PC_in = 32'h0000_0003;
        at(176);
        check("lowbits_pc", pc_bus.PC_out, EXP_3);
        check("lowbits_plus4", pc_bus.PC_plus4, EXP_3_4);
        check_mis("lowbits_mis", 1'b1);

        // Stall keeps both PC and flag even with an aligned PC_in pending.
        at(177);
        pc_bus.PC_write = 1'b0;
        pc_bus.PC_in    = 32'h0000_0010;
        at(186);
        check("lowbits_stall_pc", pc_bus.PC_out, EXP_3);
        check_mis("lowbits_stall_mis", 1'b1);

        // Load an aligned value: flag clears (edge 195).
        at(187);
        pc_bus.PC_write = 1'b1;
        at(196);
        check("aligned_pc", pc_bus.PC_out, 32'h0000_0010);
        check_mis("aligned_mis", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_program_counter
